// File: rtl/fsm_countdown.sv
// Loadable BCD M:SS countdown timer (0:00..9:59), done/err pulses.
// Ports: clk, reset (sync, active-low), en, load, ld_1..ld_3, start,
//        pause in; num_1..num_3, busy, done, err, warn out.
module fsm_countdown #(
   parameter int MAX_MIN = 9
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       en,
   input  logic       load,
   input  logic [3:0] ld_1,
   input  logic [2:0] ld_2,
   input  logic [3:0] ld_3,
   input  logic       start,
   input  logic       pause,
   output logic [3:0] num_1,
   output logic [2:0] num_2,
   output logic [3:0] num_3,
   output logic       busy,
   output logic       done,
   output logic       err,
   output logic       warn
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_RUN   = 2'd1;
   localparam logic [1:0] S_PAUSE = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   localparam logic [3:0] MAX_M = 4'(MAX_MIN);

   logic [1:0] state;
   logic [1:0] state_n;

   logic [3:0] n1_n;
   logic [2:0] n2_n;
   logic [3:0] n3_n;
   logic       done_n;
   logic       err_n;

   logic [3:0] dec_1;
   logic [2:0] dec_2;
   logic [3:0] dec_3;

   logic       ld_ok;
   logic       cnt_zero;
   logic       cnt_one;

   assign ld_ok = (ld_1 <= 4'd9)
                && (ld_2 <= 3'd5)
                && (ld_3 <= MAX_M);

   assign cnt_zero = (num_3 == 4'd0)
                   && (num_2 == 3'd0)
                   && (num_1 == 4'd0);

   assign cnt_one = (num_3 == 4'd0)
                  && (num_2 == 3'd0)
                  && (num_1 == 4'd1);

   // One-second decrement with BCD borrow chain.
   // Only used when the count is nonzero, so num_3 never wraps.
   always_comb begin
      dec_1 = num_1 - 4'd1;
      dec_2 = num_2;
      dec_3 = num_3;
      if (num_1 == 4'd0) begin
         dec_1 = 4'd9;
         if (num_2 == 3'd0) begin
            dec_2 = 3'd5;
            dec_3 = num_3 - 4'd1;
         end else begin
            dec_2 = num_2 - 3'd1;
         end
      end
   end

   always_comb begin
      state_n = state;
      n1_n    = num_1;
      n2_n    = num_2;
      n3_n    = num_3;
      done_n  = 1'b0;
      err_n   = 1'b0;
      case (state)
         S_IDLE, S_PAUSE: begin
            // Load wins over start; state is left alone.
            if (load) begin
               if (ld_ok) begin
                  n1_n = ld_1;
                  n2_n = ld_2;
                  n3_n = ld_3;
               end else begin
                  err_n = 1'b1;
               end
            end else if (start && !cnt_zero) begin
               state_n = S_RUN;
            end
         end
         S_RUN: begin
            if (pause) begin
               state_n = S_PAUSE;
            end else if (en && !cnt_zero) begin
               n1_n = dec_1;
               n2_n = dec_2;
               n3_n = dec_3;
               if (cnt_one) begin
                  state_n = S_DONE;
                  done_n  = 1'b1;
               end
            end
         end
         S_DONE: begin
            if (load) begin
               if (ld_ok) begin
                  n1_n    = ld_1;
                  n2_n    = ld_2;
                  n3_n    = ld_3;
                  state_n = S_IDLE;
               end else begin
                  err_n = 1'b1;
               end
            end
         end
         default: begin
            state_n = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state <= S_IDLE;
         num_1 <= 4'd0;
         num_2 <= 3'd0;
         num_3 <= 4'd0;
         done  <= 1'b0;
         err   <= 1'b0;
      end else begin
         state <= state_n;
         num_1 <= n1_n;
         num_2 <= n2_n;
         num_3 <= n3_n;
         done  <= done_n;
         err   <= err_n;
      end
   end

   assign busy = (state == S_RUN)
              || (state == S_PAUSE);

   assign warn = busy
              && (num_3 == 4'd0)
              && (num_2 == 3'd0)
              && (num_1 != 4'd0);

endmodule

// File: tb/tb_fsm_countdown.sv
// Bench for fsm_countdown: fixed vector table, corner sequences,
// random stimulus against a seconds-based reference model.
module tb_fsm_countdown;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       en = 1'b0;
   logic       load = 1'b0;
   logic [3:0] ld_1 = 4'd0;
   logic [2:0] ld_2 = 3'd0;
   logic [3:0] ld_3 = 4'd0;
   logic       start = 1'b0;
   logic       pause = 1'b0;
   logic [3:0] num_1;
   logic [2:0] num_2;
   logic [3:0] num_3;
   logic       busy;
   logic       done;
   logic       err;
   logic       warn;

   int n_vec = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   fsm_countdown #(.MAX_MIN(9)) dut (
      .clk   (clk),
      .reset (reset),
      .en    (en),
      .load  (load),
      .ld_1  (ld_1),
      .ld_2  (ld_2),
      .ld_3  (ld_3),
      .start (start),
      .pause (pause),
      .num_1 (num_1),
      .num_2 (num_2),
      .num_3 (num_3),
      .busy  (busy),
      .done  (done),
      .err   (err),
      .warn  (warn)
   );

   // Reference model: count kept as total seconds.
   typedef enum int {M_IDLE, M_RUN, M_PAUSE, M_DONE} mst_t;
   mst_t m_st   = M_IDLE;
   int   m_secs = 0;
   bit   m_done = 1'b0;
   bit   m_err  = 1'b0;

   task automatic model_step(
      input bit r, input bit ld,
      input int l1, input int l2, input int l3,
      input bit st, input bit pa, input bit e);
      bit ok;
      ok = (l1 <= 9) && (l2 <= 5) && (l3 <= 9);
      if (!r) begin
         m_st = M_IDLE; m_secs = 0;
         m_done = 0; m_err = 0;
         return;
      end
      m_done = 0;
      m_err  = 0;
      case (m_st)
         M_IDLE, M_PAUSE: begin
            if (ld) begin
               if (ok) m_secs = l3 * 60 + l2 * 10 + l1;
               else m_err = 1;
            end else if (st && m_secs != 0) begin
               m_st = M_RUN;
            end
         end
         M_RUN: begin
            if (pa) m_st = M_PAUSE;
            else if (e) begin
               m_secs = m_secs - 1;
               if (m_secs == 0) begin
                  m_st = M_DONE;
                  m_done = 1;
               end
            end
         end
         default: begin
            if (ld) begin
               if (ok) begin
                  m_secs = l3 * 60 + l2 * 10 + l1;
                  m_st = M_IDLE;
               end else m_err = 1;
            end
         end
      endcase
   endtask

   task automatic apply(
      input bit r, input bit ld,
      input int l1, input int l2, input int l3,
      input bit st, input bit pa, input bit e);
      reset = r; load = ld;
      ld_1 = 4'(l1); ld_2 = 3'(l2); ld_3 = 4'(l3);
      start = st; pause = pa; en = e;
      @(posedge clk);
      #1;
      model_step(r, ld, l1, l2, l3, st, pa, e);
   endtask

   task automatic cmp(
      input string nm,
      input int e3, input int e2, input int e1,
      input bit eb, input bit ed,
      input bit ee, input bit ew);
      n_vec++;
      if (num_3 !== 4'(e3) || num_2 !== 3'(e2)
          || num_1 !== 4'(e1) || busy !== eb
          || done !== ed || err !== ee
          || warn !== ew) begin
         n_bad++;
         $display("FAIL %s: got %0d:%0d%0d b%0b d%0b e%0b w%0b want %0d:%0d%0d b%0b d%0b e%0b w%0b",
            nm, num_3, num_2, num_1, busy, done, err, warn,
            e3, e2, e1, eb, ed, ee, ew);
      end
   endtask

   task automatic cmp_model(input string nm);
      bit b;
      b = (m_st == M_RUN) || (m_st == M_PAUSE);
      cmp(nm, m_secs / 60, (m_secs % 60) / 10,
          m_secs % 10, b, m_done, m_err,
          b && m_secs >= 1 && m_secs <= 9);
   endtask

   task automatic chk_int(
      input string nm, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d want %0d", nm, act, exp);
      end
   endtask

   typedef struct {
      bit    r, ld;
      int    l1, l2, l3;
      bit    st, pa, e;
      int    e3, e2, e1;
      bit    eb, ed, ee, ew;
      string nm;
   } vec_t;

   function automatic vec_t mk(
      bit r, bit ld, int l1, int l2, int l3,
      bit st, bit pa, bit e,
      int e3, int e2, int e1,
      bit eb, bit ed, bit ee, bit ew, string nm);
      vec_t v;
      v.r = r; v.ld = ld;
      v.l1 = l1; v.l2 = l2; v.l3 = l3;
      v.st = st; v.pa = pa; v.e = e;
      v.e3 = e3; v.e2 = e2; v.e1 = e1;
      v.eb = eb; v.ed = ed; v.ee = ee; v.ew = ew;
      v.nm = nm;
      return v;
   endfunction

   vec_t tbl[25];

   initial begin
      int dcnt, wcnt, dtick;
      //          r ld l1 l2 l3 st pa e  m  t  u  b d e w
      tbl[0]  = mk(0,0, 0, 0, 0, 0,0,0, 0,0,0, 0,0,0,0, "reset");
      tbl[1]  = mk(1,1, 5, 0, 1, 0,0,0, 1,0,5, 0,0,0,0, "load_105");
      tbl[2]  = mk(1,1,10, 0, 1, 0,0,0, 1,0,5, 0,0,1,0, "bad_ld1");
      tbl[3]  = mk(1,0, 0, 0, 0, 0,0,0, 1,0,5, 0,0,0,0, "err_clear");
      tbl[4]  = mk(1,1, 0, 6, 0, 0,0,0, 1,0,5, 0,0,1,0, "bad_ld2");
      tbl[5]  = mk(1,1, 0, 0,10, 0,0,0, 1,0,5, 0,0,1,0, "bad_ld3");
      tbl[6]  = mk(1,1, 0, 0, 0, 0,0,0, 0,0,0, 0,0,0,0, "load_000");
      tbl[7]  = mk(1,0, 0, 0, 0, 1,0,1, 0,0,0, 0,0,0,0, "start_zero");
      tbl[8]  = mk(1,1, 3, 0, 0, 1,0,0, 0,0,3, 0,0,0,0, "ld_beats_st");
      tbl[9]  = mk(1,0, 0, 0, 0, 1,0,0, 0,0,3, 1,0,0,1, "run_entry");
      tbl[10] = mk(1,1, 0, 0, 5, 0,0,1, 0,0,2, 1,0,0,1, "load_in_run");
      tbl[11] = mk(1,0, 0, 0, 0, 0,0,1, 0,0,1, 1,0,0,1, "dec_001");
      tbl[12] = mk(1,0, 0, 0, 0, 0,0,1, 0,0,0, 0,1,0,0, "expiry");
      tbl[13] = mk(1,0, 0, 0, 0, 1,0,1, 0,0,0, 0,0,0,0, "start_done");
      tbl[14] = mk(1,0, 0, 0, 0, 0,1,0, 0,0,0, 0,0,0,0, "pause_done");
      tbl[15] = mk(1,1, 0, 3, 0, 0,0,0, 0,3,0, 0,0,0,0, "load_done");
      tbl[16] = mk(1,0, 0, 0, 0, 1,0,0, 0,3,0, 1,0,0,0, "run_030");
      tbl[17] = mk(1,0, 0, 0, 0, 0,1,1, 0,3,0, 1,0,0,0, "pause_en");
      tbl[18] = mk(1,0, 0, 0, 0, 1,0,1, 0,3,0, 1,0,0,0, "resume");
      tbl[19] = mk(1,0, 0, 0, 0, 0,0,1, 0,2,9, 1,0,0,0, "dec_029");
      tbl[20] = mk(1,0, 0, 0, 0, 0,1,0, 0,2,9, 1,0,0,0, "pause2");
      tbl[21] = mk(1,1, 5, 1, 2, 1,0,0, 2,1,5, 1,0,0,0, "p_ld_start");
      tbl[22] = mk(1,0, 0, 0, 0, 0,0,1, 2,1,5, 1,0,0,0, "p_en_hold");
      tbl[23] = mk(1,0, 0, 0, 0, 1,0,0, 2,1,5, 1,0,0,0, "resume2");
      tbl[24] = mk(1,0, 0, 0, 0, 0,0,1, 2,1,4, 1,0,0,0, "dec_214");

      repeat (2) @(posedge clk);
      #1;
      foreach (tbl[i]) begin
         apply(tbl[i].r, tbl[i].ld, tbl[i].l1,
               tbl[i].l2, tbl[i].l3, tbl[i].st,
               tbl[i].pa, tbl[i].e);
         cmp(tbl[i].nm, tbl[i].e3, tbl[i].e2,
             tbl[i].e1, tbl[i].eb, tbl[i].ed,
             tbl[i].ee, tbl[i].ew);
      end

      // Full countdown from 1:05 with borrows.
      apply(0, 0, 0, 0, 0, 0, 0, 0);
      cmp_model("rst2");
      apply(1, 1, 5, 0, 1, 0, 0, 0);
      cmp_model("ld105b");
      apply(1, 0, 0, 0, 0, 1, 0, 0);
      cmp_model("st105");
      dcnt = 0; wcnt = 0;
      for (int k = 0; k < 65; k++) begin
         apply(1, 0, 0, 0, 0, 0, 0, 1);
         cmp_model("cd105");
         dcnt += int'(done);
         wcnt += int'(warn);
      end
      chk_int("done_count", dcnt, 1);
      chk_int("warn_count", wcnt, 9);
      apply(1, 0, 0, 0, 0, 0, 0, 1);
      cmp(
         "after_done", 0, 0, 0, 0, 0, 0, 0);

      // Reset on the expiry edge suppresses done.
      apply(1, 1, 1, 0, 0, 0, 0, 0);
      apply(1, 0, 0, 0, 0, 1, 0, 0);
      apply(0, 0, 0, 0, 0, 0, 0, 1);
      cmp("rst_expiry", 0, 0, 0, 0, 0, 0, 0);

      // Reset in RUN at 5:00.
      apply(1, 1, 0, 0, 5, 0, 0, 0);
      apply(1, 0, 0, 0, 0, 1, 0, 0);
      cmp("run_500", 5, 0, 0, 1, 0, 0, 0);
      apply(0, 0, 0, 0, 0, 1, 0, 1);
      cmp("rst_run", 0, 0, 0, 0, 0, 0, 0);

      // 9:59 needs exactly 599 ticks.
      apply(1, 1, 9, 5, 9, 0, 0, 0);
      cmp("ld_959", 9, 5, 9, 0, 0, 0, 0);
      apply(1, 0, 0, 0, 0, 1, 0, 0);
      dcnt = 0; dtick = 0;
      for (int k = 1; k <= 599; k++) begin
         apply(1, 0, 0, 0, 0, 0, 0, 1);
         cmp_model("cd959");
         if (done) begin
            dcnt++;
            dtick = k;
         end
      end
      chk_int("done_959_n", dcnt, 1);
      chk_int("done_959_t", dtick, 599);

      // Random stimulus against the model.
      for (int k = 0; k < 3000; k++) begin
         bit r, ld, st, pa, e;
         r  = ($urandom_range(63) != 0);
         ld = ($urandom_range(7) == 0);
         st = ($urandom_range(3) == 0);
         pa = ($urandom_range(15) == 0);
         e  = ($urandom_range(3) != 0);
         apply(r, ld, int'($urandom_range(15)),
               int'($urandom_range(7)),
               int'($urandom_range(15)),
               st, pa, e);
         cmp_model("rand");
      end

      $display("== %0d vectors applied, %0d miscompares ==",
               n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/fsm_countdown.md
Name: fsm_countdown

Overview:
Loadable BCD countdown timer, M:SS format, range 0:00 to 9:59. It is the down-counting companion of the team's mod-60 up-counter, with the same digit encoding on its outputs. It loads a start value, counts down one step per enable tick, and reports expiry with a one-cycle done pulse. It sits beside the up-counter in the timer subsystem and drives the same display path.

Parameters:
MAX_MIN, 9, highest legal minutes digit; load values above it are rejected.

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-low reset
en  input  1  count tick enable; one decrement per cycle with en=1 while RUN
load  input  1  load request for ld_1/ld_2/ld_3
ld_1  input  4  seconds-units value to load, 0..9
ld_2  input  3  seconds-tens value to load, 0..5
ld_3  input  4  minutes value to load, 0..MAX_MIN
start  input  1  start or resume counting
pause  input  1  freeze counting while RUN
num_1  output  4  current seconds-units digit
num_2  output  3  current seconds-tens digit
num_3  output  4  current minutes digit
busy  output  1  high in RUN or PAUSE
done  output  1  one-cycle expiry pulse
err  output  1  one-cycle pulse on a rejected load
warn  output  1  high in RUN/PAUSE when the count is 0:09 or less and nonzero

Behaviour:
- All state changes occur on the rising edge of clk.
- Reset is sampled at the clk edge with reset=0. It overrides every other input.
- Reset values: state=IDLE; num_1=0, num_2=0, num_3=0; done=0; err=0.
- busy and warn are decoded combinationally from the registers, so both are 0 during reset.
- States: IDLE, RUN, PAUSE, DONE.
- Load (IDLE, PAUSE or DONE):
  - Accepted when ld_1<=9, ld_2<=5 and ld_3<=MAX_MIN. The digits are registered at that edge.
  - An accepted load in DONE moves the state to IDLE; in IDLE or PAUSE the state is unchanged.
  - If any digit is out of range: err=1 for the next cycle only; digits and state are unchanged.
  - load is ignored in RUN; err stays 0.
- IDLE or PAUSE with start=1, load=0 and count!=0:00 -> RUN. A start with count=0:00 is ignored.
- Priority in IDLE and PAUSE: load beats start in the same cycle. The load is applied and the state does not change.
- RUN with pause=1 -> PAUSE. The count does not change on that edge, even if en=1.
- RUN, pause=0, en=1: the count decrements by one second.
  - num_1 goes 0->9 and borrows from num_2.
  - num_2 goes 0->5 and borrows from num_3.
  - Otherwise num_1 decrements alone.
- RUN, en=0: the count holds.
- Expiry: the decrement from 0:01 to 0:00 registers 0:00, sets state=DONE and sets done=1, all on the same edge. done returns to 0 on the next edge.
- done is never asserted in any other case (reset, load of 0:00, etc.).
- DONE: the count holds at 0:00. start and pause are ignored; only an accepted load leaves DONE.
- Every decrement path covers 9:59 down to 0:00. Digits never take illegal values (num_1>9, num_2>5, num_3>MAX_MIN).
- warn = busy and num_3=0 and num_2=0 and num_1!=0.
- Reset mid-RUN: the next state is IDLE with 0:00. A done pulse already in flight is cleared.
- Latency: a load is visible on the outputs 1 cycle after its edge. The first decrement can happen on the edge after the RUN entry edge.

Test Plan:
1. Reset released, load 1:05 with start=0 -> num_3/num_2/num_1 = 1/0/5, state IDLE, busy=0.
2. Start, then en=1 every cycle -> sequence 1:04 ... 1:00, 0:59 (num_1 0->9 and num_2 0->5 borrow), ... 0:01, 0:00. done=1 for exactly 1 cycle on 0:00; warn=1 from 0:09 to 0:01; busy=0 after expiry.
3. Load ld_1=10 or ld_2=6 -> err=1 for 1 cycle; previous count retained.
4. In RUN at 0:30, pause=1 with en=1 -> count stays 0:30 in PAUSE. start -> RUN; next en gives 0:29. load and start together in PAUSE -> load applied, state remains PAUSE.
5. Load 0:00 then start -> stays IDLE, done=0. Load in RUN is ignored; start in DONE is ignored.
6. reset=0 for one edge in RUN at 5:00 -> 0:00, IDLE, done=0; then load 9:59, start, 599 en ticks -> done at the 599th tick.
